mf_coeff_reverser: RTL and testbench

- Receiving end of the matched-filter coefficient stream produced by setup_MF_coeff.
- Captures LENGTH complex coefficient samples into an internal buffer.
- On request, replays them time-reversed and conjugated (h[n] = s*[LENGTH-1-n]) to the matched filter core.
- Sits between setup_MF_coeff and the matched filter MAC chain.

---
 rtl/mf_coeff_reverser_pkg.sv | 28 ++
 rtl/mf_coeff_reverser_if.sv | 29 ++
 rtl/mf_coeff_reverser_ram.sv | 31 +++
 rtl/mf_coeff_reverser.sv | 151 +++++++++++++++
 tb/tb_mf_coeff_reverser.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/mf_coeff_reverser_pkg.sv
// Shared definitions for the matched-filter coefficient reverser.
//   DATA_WIDTH_DEF / LENGTH_DEF : default component width and coefficient count
//   state_e                     : controller state encoding
//   sat_neg()                   : negate with saturation of the most negative code
package mf_coeff_reverser_pkg;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int LENGTH_DEF     = 10000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_READY = 2'd2,
    ST_READ  = 2'd3
  } state_e;

  // Works on a sign-extended value of width w; only -2^(w-1) needs clamping,
  // every other code negates exactly.
  function automatic logic signed [63:0] sat_neg(input logic signed [63:0] x,
                                                 input int unsigned        w);
    logic signed [63:0] min_v;
    logic signed [63:0] max_v;
    min_v = -(64'sd1 <<< (w - 1));
    max_v = (64'sd1 <<< (w - 1)) - 64'sd1;
    return (x == min_v) ? max_v : -x;
  endfunction

endpackage

// File: rtl/mf_coeff_reverser_if.sv
// Coefficient stream interface between setup_MF_coeff, the reverser and the
// matched filter core.
//   master : upstream side (drives enable, input stream, readStart)
//   slave  : the reverser (drives loadDone, output stream, overrunFlag)
interface mf_coeff_reverser_if #(
  parameter int DATA_WIDTH = mf_coeff_reverser_pkg::DATA_WIDTH_DEF
);
  logic                         enable;
  logic                         coeffInValid;
  logic signed [DATA_WIDTH-1:0] coeffInRe;
  logic signed [DATA_WIDTH-1:0] coeffInIm;
  logic                         readStart;
  logic                         loadDone;
  logic                         coeffOutValid;
  logic signed [DATA_WIDTH-1:0] coeffOutRe;
  logic signed [DATA_WIDTH-1:0] coeffOutIm;
  logic                         coeffOutLast;
  logic                         overrunFlag;

  modport master (
    output enable, coeffInValid, coeffInRe, coeffInIm, readStart,
    input  loadDone, coeffOutValid, coeffOutRe, coeffOutIm, coeffOutLast, overrunFlag
  );

  modport slave (
    input  enable, coeffInValid, coeffInRe, coeffInIm, readStart,
    output loadDone, coeffOutValid, coeffOutRe, coeffOutIm, coeffOutLast, overrunFlag
  );
endinterface

// File: rtl/mf_coeff_reverser_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
//   clk_i            : clock
//   we_i/waddr_i/wdata_i : write port
//   re_i/raddr_i     : read request, data appears on rdata_o one cycle later
//   rdata_o          : registered read data (holds when re_i is low)
// No reset on storage or read register so it maps onto block RAM.
module mf_coeff_reverser_ram #(
  parameter  int DEPTH = 16,
  parameter  int WIDTH = 32,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mf_coeff_reverser.sv
// Captures LENGTH complex coefficients and replays them time-reversed and
// conjugated (h[n] = s*[LENGTH-1-n]) to the matched filter core.
//   clock  : rising-edge clock
//   resetN : asynchronous active-low reset
//   bus    : slave side of mf_coeff_reverser_if (enable, input stream,
//            readStart in; loadDone, output stream, overrunFlag out)
// Replay pipeline: the first address is issued combinationally in the
// readStart cycle, the RAM registers it, then the conjugate stage registers
// the output -> first coeffOutValid two cycles after readStart.
module mf_coeff_reverser
  import mf_coeff_reverser_pkg::*;
#(
  parameter  int LENGTH     = LENGTH_DEF,
  parameter  int DATA_WIDTH = DATA_WIDTH_DEF,
  localparam int ADDR_WIDTH = (LENGTH > 1) ? $clog2(LENGTH) : 1
) (
  input  logic                clock,
  input  logic                resetN,
  mf_coeff_reverser_if.slave  bus
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(LENGTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ONE       = ADDR_WIDTH'(1);

  state_e                       state_q;
  logic [ADDR_WIDTH-1:0]        wr_cnt_q;
  logic [ADDR_WIDTH-1:0]        rd_cnt_q;   // last address issued during READ
  logic                         rd_vld_q;   // RAM read data valid
  logic                         rd_last_q;  // RAM read data is original index 0
  logic                         load_done_q;
  logic                         overrun_q;
  logic                         out_vld_q;
  logic                         out_last_q;
  logic signed [DATA_WIDTH-1:0] out_re_q;
  logic signed [DATA_WIDTH-1:0] out_im_q;

  logic                         wr_en;
  logic [ADDR_WIDTH-1:0]        wr_addr;
  logic                         rd_en;
  logic [ADDR_WIDTH-1:0]        rd_addr;
  logic [2*DATA_WIDTH-1:0]      rd_data;
  logic signed [DATA_WIDTH-1:0] rd_im;
  logic signed [DATA_WIDTH-1:0] neg_im;
  logic                         wr_last;

  // Write/read port control. Everything is gated by enable so a dropping
  // enable never touches the buffer or starts a read.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = wr_cnt_q;
    rd_en   = 1'b0;
    rd_addr = rd_cnt_q - ONE;
    if (bus.enable) begin
      case (state_q)
        ST_IDLE: begin
          // sample arriving with the IDLE->LOAD transition lands at address 0
          wr_en   = bus.coeffInValid;
          wr_addr = '0;
        end
        ST_LOAD:  wr_en = bus.coeffInValid;
        ST_READY: begin
          rd_en   = bus.readStart;
          rd_addr = LAST_ADDR;
        end
        ST_READ:  rd_en = (rd_cnt_q != '0);
        default: ;
      endcase
    end
  end

  assign wr_last = wr_en && (wr_addr == LAST_ADDR);

  mf_coeff_reverser_ram #(
    .DEPTH (LENGTH),
    .WIDTH (2 * DATA_WIDTH)
  ) u_ram (
    .clk_i   (clock),
    .we_i    (wr_en),
    .waddr_i (wr_addr),
    .wdata_i ({bus.coeffInRe, bus.coeffInIm}),
    .re_i    (rd_en),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  assign rd_im  = rd_data[DATA_WIDTH-1:0];
  assign neg_im = DATA_WIDTH'(sat_neg(64'(rd_im), DATA_WIDTH));

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q     <= ST_IDLE;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      rd_vld_q    <= 1'b0;
      rd_last_q   <= 1'b0;
      load_done_q <= 1'b0;
      overrun_q   <= 1'b0;
      out_vld_q   <= 1'b0;
      out_last_q  <= 1'b0;
      out_re_q    <= '0;
      out_im_q    <= '0;
    end else if (!bus.enable) begin
      state_q     <= ST_IDLE;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      rd_vld_q    <= 1'b0;
      rd_last_q   <= 1'b0;
      load_done_q <= 1'b0;
      overrun_q   <= 1'b0;
      out_vld_q   <= 1'b0;
      out_last_q  <= 1'b0;
      out_re_q    <= '0;
      out_im_q    <= '0;
    end else begin
      rd_vld_q   <= rd_en;
      rd_last_q  <= rd_en && (rd_addr == '0);
      out_vld_q  <= rd_vld_q;
      out_last_q <= rd_last_q;
      out_re_q   <= rd_vld_q ? rd_data[2*DATA_WIDTH-1:DATA_WIDTH] : '0;
      out_im_q   <= rd_vld_q ? neg_im : '0;

      if (wr_en)   wr_cnt_q <= wr_last ? '0 : wr_addr + ONE;
      if (rd_en)   rd_cnt_q <= rd_addr;
      if (bus.coeffInValid && (state_q == ST_READY || state_q == ST_READ))
        overrun_q <= 1'b1;

      case (state_q)
        ST_IDLE: begin
          state_q     <= wr_last ? ST_READY : ST_LOAD;
          load_done_q <= wr_last;
        end
        ST_LOAD: if (wr_last) begin
          state_q     <= ST_READY;
          load_done_q <= 1'b1;
        end
        ST_READY: if (bus.readStart) state_q <= ST_READ;
        // leave READ on the edge that registers the final output sample
        ST_READ:  if (rd_last_q) state_q <= ST_READY;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.loadDone      = load_done_q;
  assign bus.overrunFlag   = overrun_q;
  assign bus.coeffOutValid = out_vld_q;
  assign bus.coeffOutLast  = out_last_q;
  assign bus.coeffOutRe    = out_re_q;
  assign bus.coeffOutIm    = out_im_q;

endmodule

// File: tb/tb_mf_coeff_reverser.sv
module tb_mf_coeff_reverser;

  logic clk = 1'b0;
  logic resetN;
  always #5 clk = ~clk;

  mf_coeff_reverser_if #(.DATA_WIDTH(16)) bus ();

  mf_coeff_reverser #(.LENGTH(8), .DATA_WIDTH(16)) dut (
    .clock  (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  int checks   = 0;
  int failures = 0;

  int set_re [8];
  int set_im [8];

  // replay capture results
  int cap_re [16];
  int cap_im [16];
  int n_valid, first_idx, last_idx, last_pos, n_last, nz_idle;

  task automatic go_idle();
    @(negedge clk);
    bus.enable       = 1'b0;
    bus.coeffInValid = 1'b0;
    bus.readStart    = 1'b0;
  endtask

  // writes set[start .. start+cnt-1], gap idle cycles after each write
  task automatic load(input int start, input int cnt, input int gap);
    for (int k = start; k < start + cnt; k++) begin
      @(negedge clk);
      bus.enable       = 1'b1;
      bus.coeffInValid = 1'b1;
      bus.coeffInRe    = 16'(set_re[k]);
      bus.coeffInIm    = 16'(set_im[k]);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        bus.coeffInValid = 1'b0;
      end
    end
    @(negedge clk);
    bus.coeffInValid = 1'b0;
  endtask

  // pulses readStart and records 24 cycles of output; optional second
  // readStart at sample index mid (0 = none)
  task automatic replay(input int mid);
    n_valid = 0; first_idx = -1; last_idx = -1; last_pos = -1; n_last = 0; nz_idle = 0;
    @(negedge clk);
    bus.readStart = 1'b1;
    for (int s = 1; s <= 24; s++) begin
      @(negedge clk);
      bus.readStart = (s == mid);
      if (bus.coeffOutValid) begin
        if (first_idx < 0) first_idx = s;
        last_idx = s;
        if (n_valid < 16) begin
          cap_re[n_valid] = int'(bus.coeffOutRe);
          cap_im[n_valid] = int'(bus.coeffOutIm);
        end
        if (bus.coeffOutLast) begin last_pos = n_valid; n_last++; end
        n_valid++;
      end else if (bus.coeffOutRe != 0 || bus.coeffOutIm != 0 || bus.coeffOutLast) begin
        nz_idle++;
      end
    end
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    bus.enable = 1'b0; bus.coeffInValid = 1'b0; bus.readStart = 1'b0;
    bus.coeffInRe = '0; bus.coeffInIm = '0;
    repeat (2) @(negedge clk);
    checks++; if (bus.loadDone !== 1'b0) begin failures++; $display("FAIL reset_loadDone got=%b exp=0", bus.loadDone); end
    checks++; if (bus.coeffOutValid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.coeffOutValid); end
    checks++; if (bus.coeffOutRe !== 16'sd0) begin failures++; $display("FAIL reset_re got=%0d exp=0", bus.coeffOutRe); end
    checks++; if (bus.coeffOutIm !== 16'sd0) begin failures++; $display("FAIL reset_im got=%0d exp=0", bus.coeffOutIm); end
    checks++; if (bus.coeffOutLast !== 1'b0) begin failures++; $display("FAIL reset_last got=%b exp=0", bus.coeffOutLast); end
    checks++; if (bus.overrunFlag !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", bus.overrunFlag); end
    resetN = 1'b1;
  endtask

  task automatic test_basic();
    for (int k = 0; k < 8; k++) begin set_re[k] = k + 1; set_im[k] = 10 * (k + 1); end
    load(0, 7, 0);
    checks++; if (bus.loadDone !== 1'b0) begin failures++; $display("FAIL basic_loadDone_early got=%b exp=0", bus.loadDone); end
    load(7, 1, 0);
    checks++; if (bus.loadDone !== 1'b1) begin failures++; $display("FAIL basic_loadDone got=%b exp=1", bus.loadDone); end
    replay(0);
    checks++; if (first_idx != 2) begin failures++; $display("FAIL basic_latency got=%0d exp=2", first_idx); end
    checks++; if (n_valid != 8 || last_idx - first_idx != 7) begin failures++; $display("FAIL basic_count got=%0d span=%0d exp=8", n_valid, last_idx - first_idx + 1); end
    checks++; if (n_last != 1 || last_pos != 7) begin failures++; $display("FAIL basic_last got_n=%0d pos=%0d exp pos=7", n_last, last_pos); end
    checks++; if (nz_idle != 0) begin failures++; $display("FAIL basic_idle_zero got=%0d exp=0", nz_idle); end
    for (int j = 0; j < 8; j++) begin
      checks++; if (cap_re[j] != 8 - j) begin failures++; $display("FAIL basic_re[%0d] got=%0d exp=%0d", j, cap_re[j], 8 - j); end
      checks++; if (cap_im[j] != -10 * (8 - j)) begin failures++; $display("FAIL basic_im[%0d] got=%0d exp=%0d", j, cap_im[j], -10 * (8 - j)); end
    end
    checks++; if (bus.loadDone !== 1'b1) begin failures++; $display("FAIL basic_loadDone_after got=%b exp=1", bus.loadDone); end
  endtask

  task automatic test_gapped();
    go_idle();
    load(0, 8, 2);
    checks++; if (bus.loadDone !== 1'b1) begin failures++; $display("FAIL gap_loadDone got=%b exp=1", bus.loadDone); end
    replay(0);
    checks++; if (first_idx != 2 || n_valid != 8 || last_pos != 7) begin failures++; $display("FAIL gap_shape got first=%0d n=%0d lastpos=%0d exp 2/8/7", first_idx, n_valid, last_pos); end
    for (int j = 0; j < 8; j++) begin
      checks++; if (cap_re[j] != 8 - j || cap_im[j] != -10 * (8 - j)) begin
        failures++; $display("FAIL gap_data[%0d] got=%0d/%0d exp=%0d/%0d", j, cap_re[j], cap_im[j], 8 - j, -10 * (8 - j)); end
    end
  endtask

  task automatic test_saturation();
    go_idle();
    set_im[3] = -32768;
    set_im[6] = 32767;
    load(0, 8, 0);
    replay(0);
    checks++; if (n_valid != 8) begin failures++; $display("FAIL sat_count got=%0d exp=8", n_valid); end
    checks++; if (cap_im[4] != 32767) begin failures++; $display("FAIL sat_min got=%0d exp=32767", cap_im[4]); end
    checks++; if (cap_im[1] != -32767) begin failures++; $display("FAIL sat_max got=%0d exp=-32767", cap_im[1]); end
    checks++; if (cap_re[4] != 4 || cap_im[0] != -80 || cap_im[7] != -10) begin
      failures++; $display("FAIL sat_others got re4=%0d im0=%0d im7=%0d exp 4/-80/-10", cap_re[4], cap_im[0], cap_im[7]); end
  endtask

  task automatic test_overrun_repeat();
    checks++; if (bus.overrunFlag !== 1'b0) begin failures++; $display("FAIL ovr_pre got=%b exp=0", bus.overrunFlag); end
    @(negedge clk);
    bus.coeffInValid = 1'b1; bus.coeffInRe = 16'sd999; bus.coeffInIm = 16'sd999;
    @(negedge clk);
    bus.coeffInValid = 1'b0;
    checks++; if (bus.overrunFlag !== 1'b1) begin failures++; $display("FAIL ovr_set got=%b exp=1", bus.overrunFlag); end
    checks++; if (bus.loadDone !== 1'b1) begin failures++; $display("FAIL ovr_loadDone got=%b exp=1", bus.loadDone); end
    for (int r = 0; r < 2; r++) begin
      replay(r == 0 ? 0 : 4);
      checks++; if (n_valid != 8 || first_idx != 2 || n_last != 1 || last_pos != 7) begin
        failures++; $display("FAIL rep%0d_shape got n=%0d first=%0d nlast=%0d exp 8/2/1", r, n_valid, first_idx, n_last); end
      for (int j = 0; j < 8; j++) begin
        int ei;
        ei = (j == 4) ? 32767 : (j == 1) ? -32767 : -10 * (8 - j);
        checks++; if (cap_re[j] != 8 - j || cap_im[j] != ei) begin
          failures++; $display("FAIL rep%0d_data[%0d] got=%0d/%0d exp=%0d/%0d", r, j, cap_re[j], cap_im[j], 8 - j, ei); end
      end
    end
    checks++; if (bus.overrunFlag !== 1'b1) begin failures++; $display("FAIL ovr_sticky got=%b exp=1", bus.overrunFlag); end
  endtask

  task automatic test_abort();
    for (int k = 0; k < 8; k++) begin set_re[k] = 100 + k; set_im[k] = -(k + 1) * 3; end
    go_idle();
    load(0, 5, 0);
    go_idle();
    @(negedge clk);
    checks++; if (bus.loadDone !== 1'b0) begin failures++; $display("FAIL abort_loadDone got=%b exp=0", bus.loadDone); end
    checks++; if (bus.overrunFlag !== 1'b0) begin failures++; $display("FAIL abort_overrun_clr got=%b exp=0", bus.overrunFlag); end
    for (int k = 0; k < 8; k++) begin set_re[k] = 200 + k; set_im[k] = 7 * k - 20; end
    load(0, 8, 0);
    checks++; if (bus.loadDone !== 1'b1) begin failures++; $display("FAIL abort_reload got=%b exp=1", bus.loadDone); end
    replay(0);
    checks++; if (n_valid != 8) begin failures++; $display("FAIL abort_count got=%0d exp=8", n_valid); end
    for (int j = 0; j < 8; j++) begin
      checks++; if (cap_re[j] != 207 - j || cap_im[j] != 20 - 7 * (7 - j)) begin
        failures++; $display("FAIL abort_data[%0d] got=%0d/%0d exp=%0d/%0d", j, cap_re[j], cap_im[j], 207 - j, 20 - 7 * (7 - j)); end
    end
  endtask

  task automatic test_async_reset();
    int seen_vld, seen_done;
    @(negedge clk); bus.readStart = 1'b1;
    @(negedge clk); bus.readStart = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (bus.coeffOutValid !== 1'b1 || bus.coeffOutRe !== 16'sd206) begin
      failures++; $display("FAIL arst_pre got vld=%b re=%0d exp 1/206", bus.coeffOutValid, bus.coeffOutRe); end
    @(posedge clk);
    #2;
    resetN = 1'b0; bus.enable = 1'b0;
    #1;
    checks++; if (bus.coeffOutValid !== 1'b0 || bus.coeffOutRe !== 16'sd0 || bus.coeffOutIm !== 16'sd0 || bus.coeffOutLast !== 1'b0) begin
      failures++; $display("FAIL arst_out got vld=%b re=%0d im=%0d last=%b exp 0", bus.coeffOutValid, bus.coeffOutRe, bus.coeffOutIm, bus.coeffOutLast); end
    checks++; if (bus.loadDone !== 1'b0) begin failures++; $display("FAIL arst_loadDone got=%b exp=0", bus.loadDone); end
    @(negedge clk); resetN = 1'b1;
    @(negedge clk); bus.enable = 1'b1;
    @(negedge clk); bus.readStart = 1'b1;
    @(negedge clk); bus.readStart = 1'b0;
    seen_vld = 0; seen_done = 0;
    for (int s = 0; s < 6; s++) begin
      @(negedge clk);
      if (bus.coeffOutValid) seen_vld++;
      if (bus.loadDone) seen_done++;
    end
    checks++; if (seen_vld != 0 || seen_done != 0) begin
      failures++; $display("FAIL arst_noload got vld=%0d done=%0d exp 0/0", seen_vld, seen_done); end
    for (int k = 0; k < 8; k++) begin set_re[k] = -k; set_im[k] = k; end
    load(0, 8, 0);
    checks++; if (bus.loadDone !== 1'b1) begin failures++; $display("FAIL arst_reload got=%b exp=1", bus.loadDone); end
    replay(0);
    checks++; if (n_valid != 8 || cap_re[0] != -7 || cap_im[0] != -7 || cap_re[7] != 0 || last_pos != 7) begin
      failures++; $display("FAIL arst_replay got n=%0d re0=%0d im0=%0d re7=%0d exp 8/-7/-7/0", n_valid, cap_re[0], cap_im[0], cap_re[7]); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gapped();
    test_saturation();
    test_overrun_repeat();
    test_abort();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
